// File: rtl/view_pkg.sv
// Shared types for the viewer cursor controller: FSM states, key codes and
// the direction decoded from a one-hot key.
package view_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    COAST = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_XN   = 3'd1,
    DIR_XP   = 3'd2,
    DIR_YN   = 3'd3,
    DIR_YP   = 3'd4
  } dir_e;

  localparam logic [5:0] KEY_A = 6'b100000;
  localparam logic [5:0] KEY_D = 6'b010000;
  localparam logic [5:0] KEY_W = 6'b001000;
  localparam logic [5:0] KEY_S = 6'b000100;

  // Anything other than the four exact codes (zero, multi-hot) is no key.
  function automatic dir_e key_to_dir(input logic [5:0] key);
    case (key)
      KEY_A:   return DIR_XN;
      KEY_D:   return DIR_XP;
      KEY_W:   return DIR_YN;
      KEY_S:   return DIR_YP;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/view_if.sv
// Key/zoom inputs and position/size outputs of the cursor controller.
interface view_if #(
  parameter int unsigned W = 10
);
  logic [5:0]   keycode;
  logic         Zoom_In;
  logic         Zoom_Out;
  logic [W-1:0] PosX;
  logic [W-1:0] PosY;
  logic [W-1:0] Size;
  logic         Moving;

  modport master (
    output keycode, Zoom_In, Zoom_Out,
    input  PosX, PosY, Size, Moving
  );

  modport slave (
    input  keycode, Zoom_In, Zoom_Out,
    output PosX, PosY, Size, Moving
  );
endinterface

// File: rtl/view_ctrl_axis_step.sv
// One axis: signed add of velocity, clamp into [MIN+size, MAX-size], and an
// optional velocity reflection when a bound is hit.
module axis_step #(
  parameter int unsigned W      = 10,
  parameter int unsigned MIN    = 0,
  parameter int unsigned MAX    = 639,
  parameter int unsigned BOUNCE = 0
) (
  input  logic        [W-1:0] pos_i,
  input  logic        [W-1:0] size_i,
  input  logic signed [W+1:0] vel_i,
  output logic        [W-1:0] pos_o,
  output logic signed [W+1:0] vel_o
);
  localparam int unsigned SW = W + 2;

  logic signed [SW-1:0] nxt;
  logic signed [SW-1:0] lo;
  logic signed [SW-1:0] hi;

  always_comb begin
    nxt   = $signed({2'b00, pos_i}) + vel_i;
    lo    = $signed(SW'(MIN)) + $signed({2'b00, size_i});
    hi    = $signed(SW'(MAX)) - $signed({2'b00, size_i});
    pos_o = W'(nxt);
    vel_o = vel_i;
    if (nxt > hi) begin
      pos_o = W'(hi);
      if (BOUNCE != 0) vel_o = -vel_i;
    end else if (nxt < lo) begin
      pos_o = W'(lo);
      if (BOUNCE != 0) vel_o = -vel_i;
    end
  end

endmodule

// File: rtl/view_ctrl.sv
// Per-frame cursor position/size controller: key-driven velocity ramp,
// clamped or bouncing motion, and edge-triggered zoom with saturation.
module view_ctrl
  import view_pkg::*;
#(
  parameter int unsigned W            = 10,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 639,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 479,
  parameter int unsigned X_CENTER     = 320,
  parameter int unsigned Y_CENTER     = 240,
  parameter int unsigned SIZE_INIT    = 4,
  parameter int unsigned SIZE_MIN     = 2,
  parameter int unsigned SIZE_MAX     = 64,
  parameter int unsigned SIZE_STEP    = 2,
  parameter int unsigned MAX_STEP     = 8,
  parameter int unsigned ACCEL_FRAMES = 4,
  parameter int unsigned BOUNCE       = 0
) (
  input  logic  frame_clk,
  input  logic  Reset,
  view_if.slave bus
);
  localparam int unsigned VW  = W + 2;
  localparam int unsigned W1  = W + 1;
  localparam int unsigned SPW = $clog2(MAX_STEP + 1);
  localparam int unsigned HW  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  state_e               state_q, state_d;
  dir_e                 dir_q, dir_d, key;
  logic [SPW-1:0]       speed_q, speed_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic signed [VW-1:0] vx_q, vy_q, vx_d, vy_d, vx_cmd, vy_cmd, mag;
  logic [W-1:0]         posx_q, posy_q, posx_d, posy_d, size_q, size_d;
  logic [W1-1:0]        size_up;
  logic                 zin_q, zout_q, zin_rise, zout_rise;
  logic                 moving_q, moving_d;

  assign key = key_to_dir(bus.keycode);

  // Direction / speed ramp state machine.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, COAST: begin
        if (key != DIR_NONE) begin
          state_d = HOLD;
          dir_d   = key;
          speed_d = SPW'(1);
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (key == DIR_NONE) begin
          state_d = (BOUNCE != 0) ? COAST : IDLE;
        end else if (key != dir_q) begin
          dir_d   = key;
          speed_d = SPW'(1);
          hold_d  = '0;
        end else if (hold_q == HW'(ACCEL_FRAMES - 1)) begin
          hold_d = '0;
          if (speed_q < SPW'(MAX_STEP)) speed_d = speed_q + SPW'(1);
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // This frame's velocity comes from this frame's resolved state.
  always_comb begin
    mag    = VW'(speed_d);
    vx_cmd = '0;
    vy_cmd = '0;
    if (state_d == HOLD) begin
      case (dir_d)
        DIR_XN:  vx_cmd = -mag;
        DIR_XP:  vx_cmd = mag;
        DIR_YN:  vy_cmd = -mag;
        DIR_YP:  vy_cmd = mag;
        default: ;
      endcase
    end else if (state_d == COAST) begin
      vx_cmd = vx_q;
      vy_cmd = vy_q;
    end
  end

  // Zoom edges; simultaneous rising edges cancel.
  always_comb begin
    zin_rise  = bus.Zoom_In & ~zin_q;
    zout_rise = bus.Zoom_Out & ~zout_q;
    size_up   = {1'b0, size_q} + W1'(SIZE_STEP);
    size_d    = size_q;
    if (zin_rise && !zout_rise) begin
      size_d = (size_up > W1'(SIZE_MAX)) ? W'(SIZE_MAX) : W'(size_up);
    end else if (zout_rise && !zin_rise) begin
      size_d = (size_q < W'(SIZE_MIN + SIZE_STEP)) ? W'(SIZE_MIN)
                                                    : size_q - W'(SIZE_STEP);
    end
  end

  axis_step #(.W(W), .MIN(X_MIN), .MAX(X_MAX), .BOUNCE(BOUNCE)) u_axis_x (
    .pos_i (posx_q),
    .size_i(size_q),
    .vel_i (vx_cmd),
    .pos_o (posx_d),
    .vel_o (vx_d)
  );

  axis_step #(.W(W), .MIN(Y_MIN), .MAX(Y_MAX), .BOUNCE(BOUNCE)) u_axis_y (
    .pos_i (posy_q),
    .size_i(size_q),
    .vel_i (vy_cmd),
    .pos_o (posy_d),
    .vel_o (vy_d)
  );

  assign moving_d = (vx_d != '0) || (vy_d != '0);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      dir_q    <= DIR_NONE;
      speed_q  <= SPW'(1);
      hold_q   <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      posx_q   <= W'(X_CENTER);
      posy_q   <= W'(Y_CENTER);
      size_q   <= W'(SIZE_INIT);
      zin_q    <= 1'b0;
      zout_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      hold_q   <= hold_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      size_q   <= size_d;
      zin_q    <= bus.Zoom_In;
      zout_q   <= bus.Zoom_Out;
      moving_q <= moving_d;
    end
  end

  assign bus.PosX   = posx_q;
  assign bus.PosY   = posy_q;
  assign bus.Size   = size_q;
  assign bus.Moving = moving_q;

endmodule

// File: tb/tb_view_ctrl.sv
// Scoreboard bench for view_ctrl: a clamping instance and a bouncing instance
// driven with directed frame sequences and hand-computed expected outputs.
module tb_view_ctrl;

  localparam logic [5:0] KN = 6'b000000;
  localparam logic [5:0] KA = 6'b100000;
  localparam logic [5:0] KD = 6'b010000;
  localparam logic [5:0] KS = 6'b000100;

  typedef struct {
    int    at;
    int    x;
    int    y;
    int    sz;
    bit    mv;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   frame = 0;
  int   vectors = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];

  view_if #(.W(10)) bus0 ();
  view_if #(.W(10)) bus1 ();

  view_ctrl #(.BOUNCE(0)) u_clamp (.frame_clk(clk), .Reset(rst0), .bus(bus0));
  view_ctrl #(.BOUNCE(1)) u_bounce (.frame_clk(clk), .Reset(rst1), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) frame <= frame + 1;

  task automatic f0(input logic [5:0] k, input logic zi, input logic zo, input logic r);
    @(negedge clk);
    bus0.keycode = k; bus0.Zoom_In = zi; bus0.Zoom_Out = zo; rst0 = r;
  endtask

  task automatic f1(input logic [5:0] k, input logic r);
    @(negedge clk);
    bus1.keycode = k; bus1.Zoom_In = 1'b0; bus1.Zoom_Out = 1'b0; rst1 = r;
  endtask

  // Expectation for the edge following the most recent drive.
  task automatic e0(input string nm, input int x, input int y, input int sz, input bit mv);
    q0.push_back('{frame + 1, x, y, sz, mv, nm});
  endtask

  task automatic e1(input string nm, input int x, input int y, input int sz, input bit mv);
    q1.push_back('{frame + 1, x, y, sz, mv, nm});
  endtask

  task automatic chk(input exp_t e, input int x, input int y, input int sz, input bit mv);
    vectors++;
    if (x != e.x || y != e.y || sz != e.sz || mv != e.mv) begin
      fails++;
      $display("FAIL %s @frame %0d: got X=%0d Y=%0d Size=%0d Moving=%0d, want X=%0d Y=%0d Size=%0d Moving=%0d",
               e.name, frame, x, y, sz, mv, e.x, e.y, e.sz, e.mv);
    end
  endtask

  // Monitor: compare whatever expectations are due for the edge just taken.
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    while (q0.size() > 0 && q0[0].at <= frame) begin
      e = q0.pop_front();
      chk(e, int'(bus0.PosX), int'(bus0.PosY), int'(bus0.Size), bus0.Moving);
    end
    while (q1.size() > 0 && q1[0].at <= frame) begin
      e = q1.pop_front();
      chk(e, int'(bus1.PosX), int'(bus1.PosY), int'(bus1.Size), bus1.Moving);
    end
  end

  initial begin
    int rampx[10];
    int rampy[9];
    rampx = '{321, 322, 323, 324, 326, 328, 330, 332, 335, 338};
    rampy = '{241, 242, 243, 244, 246, 248, 250, 252, 255};
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.keycode = KN; bus0.Zoom_In = 1'b0; bus0.Zoom_Out = 1'b0;
    bus1.keycode = KN; bus1.Zoom_In = 1'b0; bus1.Zoom_Out = 1'b0;

    // Reset and idle
    f0(KN, 0, 0, 1); e0("rst", 320, 240, 4, 0);
    f0(KN, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin f0(KN, 0, 0, 0); e0("idle", 320, 240, 4, 0); end

    // Acceleration ramp on D, release, invalid multi-hot key
    for (int i = 0; i < 10; i++) begin f0(KD, 0, 0, 0); e0("rampD", rampx[i], 240, 4, 1); end
    f0(KN, 0, 0, 0); e0("relD", 338, 240, 4, 0);
    f0(6'b110000, 0, 0, 0); e0("multihot", 338, 240, 4, 0);

    // Drive into the right wall, then position to 630
    for (int i = 0; i < 59; i++) f0(KD, 0, 0, 0);
    f0(KD, 0, 0, 0); e0("wallD", 635, 240, 4, 1);
    f0(KN, 0, 0, 0); e0("wallRel", 635, 240, 4, 0);
    for (int i = 0; i < 4; i++) begin f0(KA, 0, 0, 0); e0("backA", 634 - i, 240, 4, 1); end
    f0(KN, 0, 0, 0); e0("idleA", 631, 240, 4, 0);
    f0(KA, 0, 0, 0); e0("nudgeA", 630, 240, 4, 1);
    f0(KN, 0, 0, 0); e0("at630", 630, 240, 4, 0);

    // From 630: D x5 clamps at 635 and stays; A restarts at speed 1
    for (int i = 0; i < 4; i++) begin f0(KD, 0, 0, 0); e0("nearD", 631 + i, 240, 4, 1); end
    f0(KD, 0, 0, 0); e0("clampD", 635, 240, 4, 1);
    f0(KD, 0, 0, 0); e0("stuckD", 635, 240, 4, 1);
    f0(KA, 0, 0, 0); e0("revA", 634, 240, 4, 1);
    f0(KN, 0, 0, 0); e0("stopA", 634, 240, 4, 0);

    // Zoom: held level counts once; size growth re-clamps X next frame
    f0(KN, 1, 0, 0); e0("zinEdge", 634, 240, 6, 0);
    f0(KN, 1, 0, 0); e0("reclamp", 633, 240, 6, 0);
    for (int i = 0; i < 3; i++) begin f0(KN, 1, 0, 0); e0("zinHeld", 633, 240, 6, 0); end
    f0(KN, 0, 0, 0); e0("zinLow", 633, 240, 6, 0);
    for (int i = 0; i < 40; i++) begin f0(KN, 1, 0, 0); f0(KN, 0, 0, 0); end
    e0("zsat", 575, 240, 64, 0);
    f0(KN, 1, 1, 0); e0("zboth", 575, 240, 64, 0);
    f0(KN, 0, 0, 0); e0("zbothLow", 575, 240, 64, 0);
    f0(KN, 0, 1, 0); e0("zout", 575, 240, 62, 0);
    f0(KN, 0, 1, 0); e0("zoutHeld", 575, 240, 62, 0);
    f0(KN, 0, 0, 0);

    // Reset mid-ramp on S, then first step after release is 1
    for (int i = 0; i < 9; i++) begin f0(KS, 0, 0, 0); e0("rampS", 575, rampy[i], 62, 1); end
    f0(KS, 0, 0, 1); e0("rstMid", 320, 240, 4, 0);
    f0(KS, 0, 0, 0); e0("postRst", 320, 241, 4, 1);
    f0(KS, 0, 0, 0); e0("postRst2", 320, 242, 4, 1);
    f0(KN, 0, 0, 0); e0("postRstRel", 320, 242, 4, 0);

    // Bounce instance: A once, direct switch to D, coast into the wall
    f1(KN, 1); e1("bRst", 320, 240, 4, 0);
    f1(KN, 0); e1("bIdle", 320, 240, 4, 0);
    f1(KA, 0); e1("bA", 319, 240, 4, 1);
    for (int i = 0; i < 8; i++) f1(KD, 0);
    f1(KD, 0); e1("bRampD", 334, 240, 4, 1);
    f1(KN, 0); e1("bCoast1", 337, 240, 4, 1);
    for (int k = 2; k < 100; k++) f1(KN, 0);
    f1(KN, 0); e1("bCoast634", 634, 240, 4, 1);
    f1(KN, 0); e1("bHit", 635, 240, 4, 1);
    f1(KN, 0); e1("bReflect", 632, 240, 4, 1);
    f1(KN, 0); e1("bReflect2", 629, 240, 4, 1);

    f0(KN, 0, 0, 0);
    f0(KN, 0, 0, 0);
    @(negedge clk);
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations never checked, want 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
